gelato_bank_arbiter: RTL and testbench

Register-file bank read arbiter for the Gelato operand-collector stage. Each operand collector presents up to three source-register read requests (rs1/rs2/rs3) for its warp. The arbiter maps every request to a register bank and grants at most one read per bank per cycle. It then drives the bank read ports and returns the data tagged with the owning collector and operand slot. It sits between the collector entries and the banked `warp_reg_t` register file.

---
 rtl/gelato_bank_arbiter.sv | 175 +++++++++++++++++
 tb/tb_gelato_bank_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_bank_arbiter.sv
// Register-file bank read arbiter: one read grant per bank per cycle, a 2-cycle issue/response pipeline, and responses tagged {collector, rs}.
// Define GELATO_BANK_ARB_RR_EN to get round-robin arbitration per bank. Without it, each bank uses fixed priority (lowest index wins).
`ifndef REG_NUM
`define REG_NUM 64
`endif
`ifndef WARP_NUM
`define WARP_NUM 8
`endif
`ifndef THREAD_NUM
`define THREAD_NUM 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module gelato_bank_arbiter #(
  parameter int COLLECTOR_NUM = 4,
  parameter int BANK_NUM      = 4,
  parameter int REG_W         = $clog2(`REG_NUM),
  parameter int WARP_W        = $clog2(`WARP_NUM),
  localparam int R            = 3 * COLLECTOR_NUM,
  localparam int COL_W        = (COLLECTOR_NUM > 1) ? $clog2(COLLECTOR_NUM) : 1,
  localparam int ADDR_W       = WARP_W + REG_W,
  localparam int DATA_W       = `THREAD_NUM * `DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [R-1:0]                 req_valid,
  input  logic [R*REG_W-1:0]           req_reg,
  input  logic [COLLECTOR_NUM*WARP_W-1:0] req_warp,
  output logic [R-1:0]                 req_ready,
  input  logic [BANK_NUM-1:0]          bank_busy,
  output logic [BANK_NUM-1:0]          bank_rd_en,
  output logic [BANK_NUM*ADDR_W-1:0]   bank_rd_addr,
  input  logic [BANK_NUM*DATA_W-1:0]   bank_rd_data,
  output logic [BANK_NUM-1:0]          resp_valid,
  output logic [BANK_NUM*COL_W-1:0]    resp_collector,
  output logic [BANK_NUM*2-1:0]        resp_rs,
  output logic [BANK_NUM*DATA_W-1:0]   resp_data
);

  localparam int BANK_W = $clog2(BANK_NUM);
  localparam logic [R-1:0] ONE_R = {{(R-1){1'b0}}, 1'b1};

  logic [BANK_W-1:0] req_bank_s [R];
  logic [R-1:0]      cand_s     [BANK_NUM];
  logic [R-1:0]      sel_s      [BANK_NUM];
  logic [R-1:0]      gnt_oh_s   [BANK_NUM];
  logic [BANK_NUM-1:0] gnt_any_s;
  logic [ADDR_W-1:0] gnt_addr_s [BANK_NUM];
  logic [COL_W-1:0]  gnt_col_s  [BANK_NUM];
  logic [1:0]        gnt_rs_s   [BANK_NUM];
  logic [R-1:0]      ready_s;

  logic [BANK_NUM-1:0]        rd_en_r;
  logic [BANK_NUM*ADDR_W-1:0] rd_addr_r;
  logic [COL_W-1:0]           tag_col_r [BANK_NUM];
  logic [1:0]                 tag_rs_r  [BANK_NUM];
  logic [BANK_NUM-1:0]        resp_valid_r;
  logic [BANK_NUM*COL_W-1:0]  resp_col_r;
  logic [BANK_NUM*2-1:0]      resp_rs_r;

`ifdef GELATO_BANK_ARB_RR_EN
  localparam int IDX_W = $clog2(R);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = {{(IDX_W-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] ptr_r      [BANK_NUM];
  logic [IDX_W-1:0] gnt_idx_s  [BANK_NUM];
  logic [R-1:0]     hi_mask_s  [BANK_NUM];
`endif

  // The low bits of (reg + warp) give the bank; only the low bits are needed for the modulo.
  for (genvar gi = 0; gi < R; gi++) begin : g_map
    assign req_bank_s[gi] = req_reg[gi*REG_W +: BANK_W] + req_warp[(gi/3)*WARP_W +: BANK_W];
  end

  // Per-bank candidate set and selection window (the RR window starts at ptr).
  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      cand_s[b] = {R{1'b0}};
      for (int i = 0; i < R; i++) begin
        cand_s[b][i] = rst_n & req_valid[i] & ~bank_busy[b] & (req_bank_s[i] == BANK_W'(b));
      end
`ifdef GELATO_BANK_ARB_RR_EN
      hi_mask_s[b] = {R{1'b0}};
      for (int i = 0; i < R; i++) begin
        hi_mask_s[b][i] = (IDX_W'(i) >= ptr_r[b]);
      end
      sel_s[b] = (|(cand_s[b] & hi_mask_s[b])) ? (cand_s[b] & hi_mask_s[b]) : cand_s[b];
`else
      sel_s[b] = cand_s[b];
`endif
    end
  end

  // Keep the lowest set bit of the selection window, then decode the winner's fields from the one-hot grant.
  always_comb begin
    ready_s = {R{1'b0}};
    for (int b = 0; b < BANK_NUM; b++) begin
      gnt_oh_s[b]   = sel_s[b] & (~sel_s[b] + ONE_R);
      gnt_any_s[b]  = |sel_s[b];
      gnt_addr_s[b] = {ADDR_W{1'b0}};
      gnt_col_s[b]  = {COL_W{1'b0}};
      gnt_rs_s[b]   = 2'b00;
`ifdef GELATO_BANK_ARB_RR_EN
      gnt_idx_s[b]  = {IDX_W{1'b0}};
`endif
      for (int i = 0; i < R; i++) begin
        gnt_addr_s[b] = gnt_addr_s[b] | ({ADDR_W{gnt_oh_s[b][i]}} &
                        {req_warp[(i/3)*WARP_W +: WARP_W], req_reg[i*REG_W +: REG_W]});
        gnt_col_s[b]  = gnt_col_s[b] | ({COL_W{gnt_oh_s[b][i]}} & COL_W'(i / 3));
        gnt_rs_s[b]   = gnt_rs_s[b] | ({2{gnt_oh_s[b][i]}} & 2'(i % 3));
`ifdef GELATO_BANK_ARB_RR_EN
        gnt_idx_s[b]  = gnt_idx_s[b] | ({IDX_W{gnt_oh_s[b][i]}} & IDX_W'(i));
`endif
      end
      ready_s = ready_s | gnt_oh_s[b];
    end
  end

  assign req_ready = ready_s;

  // Issue stage (T+1) and response stage (T+2). Reset drops every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_r      <= {BANK_NUM{1'b0}};
      rd_addr_r    <= {(BANK_NUM*ADDR_W){1'b0}};
      resp_valid_r <= {BANK_NUM{1'b0}};
      resp_col_r   <= {(BANK_NUM*COL_W){1'b0}};
      resp_rs_r    <= {(BANK_NUM*2){1'b0}};
      for (int b = 0; b < BANK_NUM; b++) begin
        tag_col_r[b] <= {COL_W{1'b0}};
        tag_rs_r[b]  <= 2'b00;
      end
    end else begin
      rd_en_r      <= gnt_any_s;
      resp_valid_r <= rd_en_r;
      for (int b = 0; b < BANK_NUM; b++) begin
        rd_addr_r[b*ADDR_W +: ADDR_W] <= gnt_addr_s[b];
        tag_col_r[b]                  <= gnt_col_s[b];
        tag_rs_r[b]                   <= gnt_rs_s[b];
        resp_col_r[b*COL_W +: COL_W]  <= tag_col_r[b];
        resp_rs_r[b*2 +: 2]           <= tag_rs_r[b];
      end
    end
  end

`ifdef GELATO_BANK_ARB_RR_EN
  // Round-robin pointer per bank: advances past the winner, and holds when there is no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        ptr_r[b] <= {IDX_W{1'b0}};
      end
    end else begin
      for (int b = 0; b < BANK_NUM; b++) begin
        if (gnt_any_s[b]) begin
          ptr_r[b] <= (gnt_idx_s[b] == LAST_IDX) ? {IDX_W{1'b0}} : gnt_idx_s[b] + ONE_IDX;
        end else begin
          ptr_r[b] <= ptr_r[b];
        end
      end
    end
  end
`endif

  assign bank_rd_en     = rd_en_r;
  assign bank_rd_addr   = rd_addr_r;
  assign resp_valid     = resp_valid_r;
  assign resp_collector = resp_col_r;
  assign resp_rs        = resp_rs_r;
  assign resp_data      = bank_rd_data;

endmodule

// File: tb/tb_gelato_bank_arbiter.sv
// Directed testbench for gelato_bank_arbiter (4 collectors, 4 banks, REG_W=6, WARP_W=3, 128-bit data).
module tb_gelato_bank_arbiter;
  localparam int C  = 4;
  localparam int B  = 4;
  localparam int R  = 12;
  localparam int RW = 6;
  localparam int WW = 3;
  localparam int AW = 9;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [R-1:0]    req_valid;
  logic [R*RW-1:0] req_reg;
  logic [C*WW-1:0] req_warp;
  logic [R-1:0]    req_ready;
  logic [B-1:0]    bank_busy;
  logic [B-1:0]    bank_rd_en;
  logic [B*AW-1:0] bank_rd_addr;
  logic [B*DW-1:0] bank_rd_data;
  logic [B-1:0]    resp_valid;
  logic [B*2-1:0]  resp_collector;
  logic [B*2-1:0]  resp_rs;
  logic [B*DW-1:0] resp_data;

  int total = 0;
  int bad = 0;

  gelato_bank_arbiter #(.COLLECTOR_NUM(C), .BANK_NUM(B), .REG_W(RW), .WARP_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_reg(req_reg), .req_warp(req_warp),
    .req_ready(req_ready), .bank_busy(bank_busy), .bank_rd_en(bank_rd_en),
    .bank_rd_addr(bank_rd_addr), .bank_rd_data(bank_rd_data), .resp_valid(resp_valid),
    .resp_collector(resp_collector), .resp_rs(resp_rs), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid    = 12'h000;
    req_reg      = '0;
    req_warp     = '0;
    bank_busy    = 4'h0;
    bank_rd_data = '0;
  endtask

  task automatic set_req(input int i, input int r);
    req_valid[i] = 1'b1;
    req_reg[i*RW +: RW] = RW'(r);
  endtask

  task automatic set_warp(input int c, input int w);
    req_warp[c*WW +: WW] = WW'(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    set_req(0, 0);
    #1;
    total++; if (req_ready !== 12'h000) begin bad++; $display("FAIL reset_ready got=%h want=000", req_ready); end
    step();
    total++; if (bank_rd_en !== 4'h0) begin bad++; $display("FAIL reset_rd_en got=%h want=0", bank_rd_en); end
    total++; if (bank_rd_addr !== 36'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bank_rd_addr); end
    total++; if (resp_valid !== 4'h0) begin bad++; $display("FAIL reset_resp_valid got=%h want=0", resp_valid); end
    total++; if (resp_collector !== 8'h00 || resp_rs !== 8'h00) begin bad++; $display("FAIL reset_tags got=%h/%h want=00/00", resp_collector, resp_rs); end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [DW-1:0] pat;
    pat = {4{32'hCAFE0004}};
    do_reset();
    set_warp(1, 2);
    set_req(4, 5);
    #1;
    total++; if (req_ready !== 12'h010) begin bad++; $display("FAIL single_ready got=%h want=010", req_ready); end
    step();
    clear_inputs();
    bank_rd_data[3*DW +: DW] = pat;
    total++; if (bank_rd_en !== 4'b1000) begin bad++; $display("FAIL single_rd_en got=%b want=1000", bank_rd_en); end
    total++; if (bank_rd_addr[3*AW +: AW] !== {3'd2, 6'd5}) begin bad++; $display("FAIL single_addr got=%h want=%h", bank_rd_addr[3*AW +: AW], {3'd2, 6'd5}); end
    step();
    total++; if (resp_valid !== 4'b1000) begin bad++; $display("FAIL single_resp_valid got=%b want=1000", resp_valid); end
    total++; if (resp_collector[6 +: 2] !== 2'd1 || resp_rs[6 +: 2] !== 2'd1) begin bad++; $display("FAIL single_tag got=%0d/%0d want=1/1", resp_collector[6 +: 2], resp_rs[6 +: 2]); end
    total++; if (resp_data[3*DW +: DW] !== pat) begin bad++; $display("FAIL single_data got=%h want=%h", resp_data[3*DW +: DW], pat); end
  endtask

  task automatic test_spread();
    do_reset();
    set_warp(1, 2);
    set_req(0, 0);
    set_req(1, 1);
    set_req(2, 2);
    set_req(3, 1);
    #1;
    total++; if (req_ready !== 12'h00F) begin bad++; $display("FAIL spread_ready got=%h want=00f", req_ready); end
    step();
    clear_inputs();
    total++; if (bank_rd_en !== 4'hF) begin bad++; $display("FAIL spread_rd_en got=%h want=f", bank_rd_en); end
    total++; if (bank_rd_addr[3*AW +: AW] !== {3'd2, 6'd1} || bank_rd_addr[1*AW +: AW] !== {3'd0, 6'd1}) begin
      bad++; $display("FAIL spread_addr got=%h want=%h/%h", bank_rd_addr, {3'd2, 6'd1}, {3'd0, 6'd1});
    end
    step();
    total++; if (resp_valid !== 4'hF) begin bad++; $display("FAIL spread_resp_valid got=%h want=f", resp_valid); end
    total++; if (resp_collector !== 8'h40) begin bad++; $display("FAIL spread_collector got=%h want=40", resp_collector); end
    total++; if (resp_rs !== 8'h24) begin bad++; $display("FAIL spread_rs got=%h want=24", resp_rs); end
  endtask

  task automatic test_contention();
    logic [R-1:0] exp;
    do_reset();
    set_req(0, 0);
    set_req(3, 0);
    set_req(6, 0);
    for (int k = 0; k < 6; k++) begin
`ifdef GELATO_BANK_ARB_RR_EN
      exp = 12'h001 << (3 * (k % 3));
`else
      exp = 12'h001;
`endif
      #1;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL contention_cycle%0d got=%h want=%h", k, req_ready, exp); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_busy();
    do_reset();
    set_req(2, 2);
    bank_busy = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_ready !== 12'h000) begin bad++; $display("FAIL busy_ready_cycle%0d got=%h want=000", k, req_ready); end
      step();
      total++; if (bank_rd_en !== 4'h0) begin bad++; $display("FAIL busy_rd_en_cycle%0d got=%h want=0", k, bank_rd_en); end
    end
    bank_busy = 4'h0;
    #1;
    total++; if (req_ready !== 12'h004) begin bad++; $display("FAIL busy_release_ready got=%h want=004", req_ready); end
    step();
    clear_inputs();
    total++; if (bank_rd_en !== 4'b0100) begin bad++; $display("FAIL busy_release_rd_en got=%b want=0100", bank_rd_en); end
    step();
    total++; if (resp_valid !== 4'b0100 || resp_rs[4 +: 2] !== 2'd2) begin bad++; $display("FAIL busy_resp got=%b/%0d want=0100/2", resp_valid, resp_rs[4 +: 2]); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_warp(3, 0);
    set_req(11, 1);
    #1;
    total++; if (req_ready !== 12'h800) begin bad++; $display("FAIL wrap_first_ready got=%h want=800", req_ready); end
    step();
    clear_inputs();
    set_req(0, 1);
    set_req(11, 1);
    #1;
    total++; if (req_ready !== 12'h001) begin bad++; $display("FAIL wrap_second_ready got=%h want=001", req_ready); end
    step();
    clear_inputs();
    total++; if (resp_valid !== 4'b0010 || resp_collector[2 +: 2] !== 2'd3 || resp_rs[2 +: 2] !== 2'd2) begin
      bad++; $display("FAIL wrap_resp_first got=%b/%0d/%0d want=0010/3/2", resp_valid, resp_collector[2 +: 2], resp_rs[2 +: 2]);
    end
    step();
    total++; if (resp_valid !== 4'b0010 || resp_collector[2 +: 2] !== 2'd0 || resp_rs[2 +: 2] !== 2'd0) begin
      bad++; $display("FAIL wrap_resp_second got=%b/%0d/%0d want=0010/0/0", resp_valid, resp_collector[2 +: 2], resp_rs[2 +: 2]);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    set_req(0, 0);
    #1;
    total++; if (req_ready !== 12'h001) begin bad++; $display("FAIL rstfl_pre_ready got=%h want=001", req_ready); end
    step();
    total++; if (bank_rd_en !== 4'b0001) begin bad++; $display("FAIL rstfl_pre_rd_en got=%b want=0001", bank_rd_en); end
    rst_n = 1'b0;
    set_req(3, 0);
    #1;
    total++; if (bank_rd_en !== 4'h0 || req_ready !== 12'h000) begin bad++; $display("FAIL rstfl_in_reset got=%h/%h want=0/000", bank_rd_en, req_ready); end
    step();
    total++; if (resp_valid !== 4'h0) begin bad++; $display("FAIL rstfl_resp_dropped got=%h want=0", resp_valid); end
    step();
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 12'h001) begin bad++; $display("FAIL rstfl_post_ready got=%h want=001", req_ready); end
    step();
    clear_inputs();
    step();
    total++; if (resp_valid !== 4'b0001 || resp_collector[0 +: 2] !== 2'd0) begin bad++; $display("FAIL rstfl_post_resp got=%b/%0d want=0001/0", resp_valid, resp_collector[0 +: 2]); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_spread();
    test_contention();
    test_busy();
    test_wrap();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
